coil_sequencer: RTL and testbench
=================================

COIL_SEQUENCER -- requirements
Module: coil_sequencer

Interface
REQ-001 SHALL have parameter NCOIL, default 4, number of coil stages (2..8).
REQ-002 SHALL have parameter PULSE_MAX, default 50000, maximum on-time per coil in clock cycles (24-bit).
REQ-003 SHALL have parameter COOLDOWN, default 100000, post-shot holdoff in clock cycles (24-bit).
REQ-004 SHALL have port I_clk, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port I_rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port I_creg, input, 8, I2C control register: bit0 ARM (level), bit1 FIRE (rising edge), bit2 CLR (rising edge), bits 7:3 ignored.
REQ-007 SHALL have port I_sense, input, NCOIL, asynchronous projectile gates, high = projectile at coil k centre.
REQ-008 SHALL have port O_coil, output, NCOIL, coil drive enables, registered.
REQ-009 SHALL have port O_eflg, output, 8, sticky error flags for I2C readback.
REQ-010 SHALL have port O_acc, output, 24, transit time in cycles, sense[0] to sense[NCOIL-1].
REQ-011 SHALL have port O_busy, output, 1, high in any state other than IDLE and ARMED.

Function
REQ-012 SHALL pass I_sense through a two-flop synchronizer; all uses below refer to the synchronized value s[k].
REQ-013 SHALL detect FIRE and CLR edges by comparing I_creg with a registered copy (one-cycle detect).
REQ-014 SHALL implement states IDLE, ARMED, PULSE, COOL, FAULT.
REQ-015 IDLE -> ARMED when ARM=1 and FLT (eflg[7]) = 0; ARMED -> IDLE when ARM=0.
REQ-016 FIRE edge in IDLE SHALL set eflg[2] (fire-not-armed) and remain in IDLE.
REQ-017 FIRE edge in ARMED with any s[k]=1 SHALL set eflg[1] (blocked), enter FAULT, and drive no coil.
REQ-018 FIRE edge in ARMED with all s=0 SHALL enter PULSE with index k=0, clear O_acc to 0, and clear the pulse timer, with O_coil[0]=1 from the following cycle.
REQ-019 In PULSE at most one O_coil bit SHALL ever be high, namely bit k.
REQ-020 In PULSE, s[k] rising SHALL deassert coil k; if k<NCOIL-1, coil k+1 SHALL assert in the same cycle (no gap, no overlap) and the timer SHALL reset; if k=NCOIL-1, the block SHALL enter COOL.
REQ-021 Latency from raw I_sense[k] rise to the O_coil change SHALL be 3 cycles.
REQ-022 The timer reaching PULSE_MAX with s[k]=0 SHALL set eflg[0] (timeout) and enter FAULT.
REQ-023 s[j]=1 for any j>k while in PULSE SHALL set eflg[3] (out-of-order) and enter FAULT; this check takes precedence over REQ-020 in the same cycle.
REQ-024 ARM falling while in PULSE SHALL set eflg[4] (abort) and enter IDLE, with all coils off the next cycle.
REQ-025 On any fault, eflg[6:5] SHALL record k[1:0] and eflg[7] SHALL be set; O_coil SHALL be all-zero in FAULT and COOL.
REQ-026 O_acc SHALL increment each cycle from the s[0] rise to the s[NCOIL-1] rise, saturating at 0xFFFFFF, and hold its value until the next accepted FIRE.
REQ-027 COOL SHALL last COOLDOWN cycles, then go to ARMED if ARM=1, otherwise to IDLE; FIRE edges during COOL SHALL be ignored.
REQ-028 FAULT SHALL be left only on a CLR edge, which zeroes O_eflg and goes to IDLE.
REQ-029 A CLR edge in other states SHALL zero O_eflg without changing state.
REQ-030 If a fault set and CLR occur in the same cycle, the set SHALL win.

Reset
REQ-031 On I_rst_n low, the block SHALL immediately set state=IDLE, O_coil=0, O_eflg=0, O_acc=0, O_busy=0, timers=0, and synchronizer and edge registers=0.
REQ-032 Reset mid-PULSE SHALL drop all coils asynchronously, with no further pulse until a new ARM plus FIRE.

Structure
REQ-033 A shared package SHALL hold the state encoding, creg bit indices (ARM, FIRE, CLR), and eflg bit indices (TMO, BLK, NARM, ORD, ABT, IDX, FLT).
REQ-034 Synchronizer SHALL be the sub-module sync2 (parameterized width), instantiated once for I_sense.

Verification (NCOIL=4, PULSE_MAX=100, COOLDOWN=20)
REQ-035 Normal shot: ARM=1, FIRE edge, raise sense[0..3] at 30-cycle spacing -> coils 0..3 each high in turn, never two at once, O_acc=90, COOL for 20 cycles, then ARMED.
REQ-036 Timeout: FIRE, sense[0] at cycle 30, sense[1] never -> coil1 off after 100 cycles, O_eflg=0xA1 (FLT, idx=1, TMO), FAULT; CLR edge -> O_eflg=0, IDLE.
REQ-037 Blocked and not-armed cases: sense[2]=1 then FIRE in ARMED -> O_eflg=0x82, no coil pulse; FIRE with ARM=0 -> O_eflg=0x04.
REQ-038 Out-of-order: during coil0, raise sense[2] -> O_eflg=0x88, coils off, FAULT.
REQ-039 Abort and reset: drop ARM during coil1 -> O_eflg=0x30, coils off next cycle; in a separate run, assert I_rst_n=0 during coil2 -> O_coil=0 asynchronously, all outputs zero.

Source files
------------

// File: rtl/coil_sequencer_pkg.sv
// Shared definitions for the coil sequencer: state encoding plus the bit
// positions of the control register and the error-flag register.
package coil_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_PULSE = 3'd2,
        ST_COOL  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam int CREG_ARM  = 0;
    localparam int CREG_FIRE = 1;
    localparam int CREG_CLR  = 2;

    localparam int EFLG_TMO    = 0;
    localparam int EFLG_BLK    = 1;
    localparam int EFLG_NARM   = 2;
    localparam int EFLG_ORD    = 3;
    localparam int EFLG_ABT    = 4;
    localparam int EFLG_IDX_LO = 5;
    localparam int EFLG_IDX_HI = 6;
    localparam int EFLG_FLT    = 7;

    localparam logic [23:0] ACC_MAX = 24'hFF_FFFF;

endpackage

// File: rtl/coil_sequencer_sync2.sv
// Two-flop synchronizer for asynchronous level inputs, any width.
module sync2 #(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] d_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_p0 <= '0;
            q    <= '0;
        end else begin
            d_p0 <= d;
            q    <= d_p0;
        end
    end

endmodule

// File: rtl/coil_sequencer.sv
// Multi-stage coil sequencer: fires coils in order as the projectile reaches
// each gate, measures transit time and latches sticky error flags.
module coil_sequencer
    import coil_sequencer_pkg::*;
#(
    parameter int NCOIL     = 4,
    parameter int PULSE_MAX = 50000,
    parameter int COOLDOWN  = 100000
) (
    input  logic             I_clk,
    input  logic             I_rst_n,
    input  logic [7:0]       I_creg,
    input  logic [NCOIL-1:0] I_sense,
    output logic [NCOIL-1:0] O_coil,
    output logic [7:0]       O_eflg,
    output logic [23:0]      O_acc,
    output logic             O_busy
);

    localparam logic [23:0] PULSE_LAST = 24'(PULSE_MAX - 1);
    localparam logic [23:0] COOL_LAST  = 24'(COOLDOWN - 1);
    localparam logic [2:0]  K_LAST     = 3'(NCOIL - 1);

    state_t           state, state_d;
    logic [2:0]       k, k_d;
    logic [23:0]      timer, timer_d;
    logic [23:0]      acc, acc_d;
    logic [7:0]       eflg, eflg_d;
    logic [7:0]       set_bits;
    logic             rec_idx;
    logic [NCOIL-1:0] s, s_above, coil, coil_d;
    logic             fire_q, clr_q;
    logic             arm, fire, clr, s_cur, ahead;
    logic             unused_creg;

    sync2 #(.DATA_W(NCOIL)) u_sense_sync (
        .clk   (I_clk),
        .rst_n (I_rst_n),
        .d     (I_sense),
        .q     (s)
    );

    assign arm         = I_creg[CREG_ARM];
    assign fire        = I_creg[CREG_FIRE] & ~fire_q;
    assign clr         = I_creg[CREG_CLR] & ~clr_q;
    assign unused_creg = ^I_creg[7:3];

    // s_cur is the gate of the active coil; ahead flags any gate beyond it
    assign s_cur   = |(s & (NCOIL'(1) << k));
    assign s_above = (s >> k) >> 1;
    assign ahead   = |s_above;

    always_comb begin
        state_d  = state;
        k_d      = k;
        timer_d  = timer;
        acc_d    = acc;
        set_bits = '0;
        rec_idx  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fire) begin
                    set_bits[EFLG_NARM] = 1'b1;
                end else if (arm && !eflg[EFLG_FLT]) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!arm) begin
                    state_d = ST_IDLE;
                end else if (fire) begin
                    if (|s) begin
                        set_bits[EFLG_BLK] = 1'b1;
                        set_bits[EFLG_FLT] = 1'b1;
                        rec_idx            = 1'b1;
                        state_d            = ST_FAULT;
                    end else begin
                        state_d = ST_PULSE;
                        k_d     = '0;
                        timer_d = '0;
                        acc_d   = '0;
                    end
                end
            end
            ST_PULSE: begin
                // transit clock runs from the first gate to the last one
                if (k != '0 && acc != ACC_MAX) begin
                    acc_d = acc + 24'd1;
                end
                if (ahead) begin
                    set_bits[EFLG_ORD] = 1'b1;
                    set_bits[EFLG_FLT] = 1'b1;
                    rec_idx            = 1'b1;
                    state_d            = ST_FAULT;
                    k_d                = '0;
                end else if (!arm) begin
                    set_bits[EFLG_ABT] = 1'b1;
                    rec_idx            = 1'b1;
                    state_d            = ST_IDLE;
                    k_d                = '0;
                end else if (s_cur) begin
                    timer_d = '0;
                    if (k == K_LAST) begin
                        state_d = ST_COOL;
                        k_d     = '0;
                    end else begin
                        k_d = k + 3'd1;
                    end
                end else if (timer == PULSE_LAST) begin
                    set_bits[EFLG_TMO] = 1'b1;
                    set_bits[EFLG_FLT] = 1'b1;
                    rec_idx            = 1'b1;
                    state_d            = ST_FAULT;
                    k_d                = '0;
                end else begin
                    timer_d = timer + 24'd1;
                end
            end
            ST_COOL: begin
                if (timer == COOL_LAST) begin
                    state_d = arm ? ST_ARMED : ST_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer + 24'd1;
                end
            end
            ST_FAULT: begin
                if (clr) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // a flag being raised in the same cycle as CLR survives the clear
        eflg_d = clr ? 8'h00 : eflg;
        eflg_d = eflg_d | set_bits;
        if (rec_idx) begin
            eflg_d[EFLG_IDX_HI:EFLG_IDX_LO] = k[1:0];
        end

        coil_d = (state_d == ST_PULSE) ? (NCOIL'(1) << k_d) : '0;
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state  <= ST_IDLE;
            k      <= '0;
            timer  <= '0;
            acc    <= '0;
            eflg   <= '0;
            coil   <= '0;
            fire_q <= 1'b0;
            clr_q  <= 1'b0;
        end else begin
            state  <= state_d;
            k      <= k_d;
            timer  <= timer_d;
            acc    <= acc_d;
            eflg   <= eflg_d;
            coil   <= coil_d;
            fire_q <= I_creg[CREG_FIRE];
            clr_q  <= I_creg[CREG_CLR];
        end
    end

    assign O_coil = coil;
    assign O_eflg = eflg;
    assign O_acc  = acc;
    assign O_busy = (state == ST_PULSE) || (state == ST_COOL) || (state == ST_FAULT);

endmodule

// File: tb/tb_coil_sequencer.sv
// Bench for coil_sequencer: directed shots with hand-derived expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_coil_sequencer;

    localparam int NCOIL = 4;
    localparam int PM    = 100;
    localparam int CD    = 20;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_PULSE = 2;
    localparam int M_COOL  = 3;
    localparam int M_FAULT = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       creg;
    logic [NCOIL-1:0] sense;
    logic [NCOIL-1:0] coil;
    logic [7:0]       eflg;
    logic [23:0]      acc;
    logic             busy;

    int errors = 0;
    int checks = 0;

    // behavioural model state
    int               m_mode = M_IDLE;
    int               m_idx  = 0;
    int               m_cnt  = 0;
    logic [23:0]      m_acc  = '0;
    logic [7:0]       m_eflg = '0;
    logic [NCOIL-1:0] m_sd1  = '0;
    logic [NCOIL-1:0] m_sd2  = '0;
    logic [7:0]       m_cprev = '0;

    coil_sequencer #(
        .NCOIL     (NCOIL),
        .PULSE_MAX (PM),
        .COOLDOWN  (CD)
    ) dut (
        .I_clk   (clk),
        .I_rst_n (rst_n),
        .I_creg  (creg),
        .I_sense (sense),
        .O_coil  (coil),
        .O_eflg  (eflg),
        .O_acc   (acc),
        .O_busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic raise_fault(input int bitpos, input int k);
        m_eflg[bitpos] = 1'b1;
        m_eflg[7]      = 1'b1;
        m_eflg[6:5]    = 2'(k);
        m_mode         = M_FAULT;
        m_idx          = 0;
    endtask

    task automatic model_step();
        logic [NCOIL-1:0] sv;
        logic [7:0]       old;
        logic             arm, fire, clr;
        int               k;
        sv   = m_sd2;
        old  = m_eflg;
        arm  = creg[0];
        fire = creg[1] & ~m_cprev[1];
        clr  = creg[2] & ~m_cprev[2];
        k    = m_idx;
        if (clr) m_eflg = 8'h00;
        if (m_mode == M_PULSE && k >= 1 && m_acc != 24'hFFFFFF) m_acc = m_acc + 24'd1;
        case (m_mode)
            M_IDLE: begin
                if (fire) m_eflg[2] = 1'b1;
                else if (arm && !old[7]) m_mode = M_ARMED;
            end
            M_ARMED: begin
                if (!arm) m_mode = M_IDLE;
                else if (fire && sv != 0) raise_fault(1, k);
                else if (fire) begin
                    m_mode = M_PULSE;
                    m_idx  = 0;
                    m_cnt  = 0;
                    m_acc  = '0;
                end
            end
            M_PULSE: begin
                if ((sv >> (k + 1)) != 0) raise_fault(3, k);
                else if (!arm) begin
                    m_eflg[4]   = 1'b1;
                    m_eflg[6:5] = 2'(k);
                    m_mode      = M_IDLE;
                    m_idx       = 0;
                end else if (sv[k]) begin
                    if (k == NCOIL - 1) begin
                        m_mode = M_COOL;
                        m_idx  = 0;
                    end else begin
                        m_idx = k + 1;
                    end
                    m_cnt = 0;
                end else if (m_cnt + 1 == PM) raise_fault(0, k);
                else m_cnt++;
            end
            M_COOL: begin
                m_cnt++;
                if (m_cnt == CD) begin
                    m_mode = arm ? M_ARMED : M_IDLE;
                    m_cnt  = 0;
                end
            end
            M_FAULT: if (clr) m_mode = M_IDLE;
            default: m_mode = M_IDLE;
        endcase
        m_sd2   = m_sd1;
        m_sd1   = sense;
        m_cprev = creg;
    endtask

    function automatic logic [NCOIL-1:0] m_coil();
        return (m_mode == M_PULSE) ? (NCOIL'(1) << m_idx) : '0;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode  = M_IDLE;
            m_idx   = 0;
            m_cnt   = 0;
            m_acc   = '0;
            m_eflg  = '0;
            m_sd1   = '0;
            m_sd2   = '0;
            m_cprev = '0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("cyc_coil", 32'(coil), 32'(m_coil()));
            check("cyc_eflg", 32'(eflg), 32'(m_eflg));
            check("cyc_acc", 32'(acc), 32'(m_acc));
            check("cyc_busy", 32'(busy), 32'(m_mode >= M_PULSE));
            check("cyc_onehot", 32'($countones(coil) <= 1), 32'd1);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_fire();
        creg[1] = 1'b1;
        @(negedge clk);
        creg[1] = 1'b0;
    endtask

    task automatic pulse_clr();
        creg[2] = 1'b1;
        @(negedge clk);
        creg[2] = 1'b0;
    endtask

    task automatic pulse_sense(input int i, input int len);
        sense[i] = 1'b1;
        cyc(len);
        sense[i] = 1'b0;
    endtask

    task automatic wait_coil(input logic [NCOIL-1:0] val, input int budget, input string name);
        for (int i = 0; i < budget && coil !== val; i++) @(negedge clk);
        check(name, 32'(coil), 32'(val));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi [NCOIL];
        int cool_cnt;
        int tmo_cnt;
        int j;

        rst_n = 1'b1;
        creg  = 8'h00;
        sense = '0;
        #1 rst_n = 1'b0;
        #1;
        check("reset_coil", 32'(coil), 0);
        check("reset_eflg", 32'(eflg), 0);
        check("reset_acc", 32'(acc), 0);
        check("reset_busy", 32'(busy), 0);
        cyc(3);
        rst_n = 1'b1;

        // normal shot, gates 30 cycles apart
        creg = 8'h01;
        cyc(3);
        check("armed_busy", 32'(busy), 0);
        pulse_fire();
        check("shot_coil0", 32'(coil), 1);
        foreach (hi[i]) hi[i] = 0;
        cool_cnt = 0;
        for (int t = 0; t < 150; t++) begin
            for (int i = 0; i < NCOIL; i++) if (coil == (NCOIL'(1) << i)) hi[i]++;
            if (busy && coil == 0) cool_cnt++;
            for (int i = 0; i < NCOIL; i++) sense[i] = (t >= 10 + 30 * i && t < 13 + 30 * i);
            @(negedge clk);
        end
        check("shot_hi0", 32'(hi[0]), 13);
        check("shot_hi1", 32'(hi[1]), 30);
        check("shot_hi2", 32'(hi[2]), 30);
        check("shot_hi3", 32'(hi[3]), 30);
        check("shot_acc", 32'(acc), 90);
        check("shot_cool", 32'(cool_cnt), CD);
        check("shot_armed", 32'(busy), 0);

        // timeout on coil 1
        pulse_fire();
        tmo_cnt = 0;
        for (int t = 0; t < 200; t++) begin
            if (coil == 4'b0010) tmo_cnt++;
            sense[0] = (t >= 27 && t < 30);
            @(negedge clk);
        end
        check("tmo_on_cycles", 32'(tmo_cnt), PM);
        check("tmo_eflg", 32'(eflg), 32'hA1);
        check("tmo_busy", 32'(busy), 1);
        pulse_clr();
        check("tmo_clr_eflg", 32'(eflg), 0);
        check("tmo_clr_idle", 32'(busy), 0);

        // blocked gate at fire time
        sense[2] = 1'b1;
        cyc(3);
        pulse_fire();
        check("blk_eflg", 32'(eflg), 32'h82);
        check("blk_coil", 32'(coil), 0);
        sense = '0;
        cyc(5);
        check("blk_nopulse", 32'(coil), 0);
        pulse_clr();
        check("blk_clr", 32'(eflg), 0);

        // fire while not armed
        creg = 8'h00;
        cyc(3);
        pulse_fire();
        check("narm_eflg", 32'(eflg), 32'h04);
        check("narm_busy", 32'(busy), 0);
        pulse_clr();
        check("narm_clr", 32'(eflg), 0);

        // gate 2 seen while coil 0 is driven
        creg = 8'h01;
        cyc(3);
        pulse_fire();
        cyc(5);
        sense[2] = 1'b1;
        cyc(3);
        check("ord_eflg", 32'(eflg), 32'h88);
        check("ord_coil", 32'(coil), 0);
        sense[2] = 1'b0;
        pulse_clr();
        check("ord_clr", 32'(eflg), 0);

        // abort by dropping ARM during coil 1
        cyc(3);
        pulse_fire();
        cyc(5);
        pulse_sense(0, 3);
        wait_coil(4'b0010, 10, "abt_coil1");
        cyc(5);
        creg[0] = 1'b0;
        check("abt_pre", 32'(coil), 32'h2);
        @(negedge clk);
        check("abt_coil", 32'(coil), 0);
        check("abt_eflg", 32'(eflg), 32'h30);
        pulse_clr();

        // asynchronous reset during coil 2
        creg = 8'h01;
        cyc(3);
        pulse_fire();
        cyc(4);
        pulse_sense(0, 3);
        cyc(4);
        pulse_sense(1, 3);
        wait_coil(4'b0100, 10, "rst_coil2");
        cyc(3);
        #2 rst_n = 1'b0;
        creg  = 8'h00;
        sense = '0;
        #1;
        check("rst_coil", 32'(coil), 0);
        check("rst_eflg", 32'(eflg), 0);
        check("rst_acc", 32'(acc), 0);
        check("rst_busy", 32'(busy), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
        creg = 8'h01;
        cyc(10);
        check("rst_nopulse", 32'(coil), 0);

        // randomized shots with occasional misordering, aborts, long gaps
        for (int r = 0; r < 40; r++) begin
            creg[0] = ($urandom_range(0, 7) != 0);
            cyc(int'($urandom_range(1, 5)));
            pulse_fire();
            for (int i = 0; i < NCOIL; i++) begin
                if ($urandom_range(0, 9) == 0) cyc(int'($urandom_range(2, 110)));
                else cyc(int'($urandom_range(2, 60)));
                j = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, NCOIL - 1)) : i;
                pulse_sense(j, int'($urandom_range(1, 4)));
                if ($urandom_range(0, 19) == 0) creg[0] = 1'b0;
                if ($urandom_range(0, 29) == 0) pulse_fire();
            end
            cyc(int'($urandom_range(0, 30)));
            if ($urandom_range(0, 2) != 0) pulse_clr();
        end

        // unstructured noise on every input
        for (int n = 0; n < 2000; n++) begin
            creg[0]   = ($urandom_range(0, 15) != 0);
            creg[1]   = ($urandom_range(0, 3) == 0);
            creg[2]   = ($urandom_range(0, 31) == 0);
            creg[7:3] = 5'($urandom);
            for (int i = 0; i < NCOIL; i++) sense[i] = ($urandom_range(0, 29) == 0);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
